// File: rtl/regfile_2r1w_if.sv
// Register-file bus: one byte-enabled write port, two read ports, bulk clear.
interface regfile_2r1w_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / 8;

  logic              we;
  logic [AW-1:0]     waddr;
  logic [WIDTH-1:0]  wdata;
  logic [NB-1:0]     wbe;
  logic [AW-1:0]     raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic [AW-1:0]     raddr_b;
  logic [WIDTH-1:0]  rdata_b;
  logic              clr;
  logic              busy;
  logic              wr_drop;

  modport master (
    output we, waddr, wdata, wbe, raddr_a, raddr_b, clr,
    input  rdata_a, rdata_b, busy, wr_drop
  );

  modport slave (
    input  we, waddr, wdata, wbe, raddr_a, raddr_b, clr,
    output rdata_a, rdata_b, busy, wr_drop
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with byte enables, optional zero entry,
// optional write-to-read bypass, optional registered reads and a
// one-entry-per-cycle bulk clear sequencer.
module regfile_2r1w #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          READ_REG = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  regfile_2r1w_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / 8;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic             busy_q;

  logic             waddr_ok;
  logic             wr_acc;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merge;
  logic [WIDTH-1:0] rdata_a_d;
  logic [WIDTH-1:0] rdata_b_d;

  // Write qualification and byte-enable merge with the stored word
  always_comb begin
    waddr_ok = 32'(bus.waddr) < DEPTH;
    wr_acc   = bus.we && !busy_q && waddr_ok && !(ZERO_REG && (bus.waddr == '0));
    wr_old   = waddr_ok ? mem_q[bus.waddr] : '0;
    wr_merge = wr_old;
    for (int unsigned b = 0; b < NB; b++) begin
      if (bus.wbe[b]) begin
        wr_merge[8*b +: 8] = bus.wdata[8*b +: 8];
      end
    end
  end

  // Next array contents: accepted write, or one entry zeroed by the sweep
  always_comb begin
    mem_d = mem_q;
    if (wr_acc) begin
      mem_d[bus.waddr] = wr_merge;
    end
    if (state_q == ST_CLEAR) begin
      mem_d[cnt_q] = '0;
    end
  end

  // Storage array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Bulk-clear sequencer; busy mirrors the CLEAR state as a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.clr) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read port A value: range/zero masking, then same-cycle bypass
  always_comb begin
    rdata_a_d = '0;
    if ((32'(bus.raddr_a) < DEPTH) && !(ZERO_REG && (bus.raddr_a == '0))) begin
      if (BYPASS && wr_acc && (bus.raddr_a == bus.waddr)) begin
        rdata_a_d = wr_merge;
      end else begin
        rdata_a_d = mem_q[bus.raddr_a];
      end
    end
  end

  // Read port B value: range/zero masking, then same-cycle bypass
  always_comb begin
    rdata_b_d = '0;
    if ((32'(bus.raddr_b) < DEPTH) && !(ZERO_REG && (bus.raddr_b == '0))) begin
      if (BYPASS && wr_acc && (bus.raddr_b == bus.waddr)) begin
        rdata_b_d = wr_merge;
      end else begin
        rdata_b_d = mem_q[bus.raddr_b];
      end
    end
  end

  generate
    if (READ_REG) begin : g_rd_reg
      logic [WIDTH-1:0] rdata_a_q;
      logic [WIDTH-1:0] rdata_b_q;

      // Registered read data, one cycle after the address
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_a_q <= '0;
          rdata_b_q <= '0;
        end else begin
          rdata_a_q <= rdata_a_d;
          rdata_b_q <= rdata_b_d;
        end
      end

      assign bus.rdata_a = rdata_a_q;
      assign bus.rdata_b = rdata_b_q;
    end else begin : g_rd_comb
      assign bus.rdata_a = rdata_a_d;
      assign bus.rdata_b = rdata_b_d;
    end
  endgenerate

  assign bus.busy    = busy_q;
  // Rejection flag is combinational so it lines up with the dropped write
  assign bus.wr_drop = bus.we & busy_q;
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised successor to the single 32-bit enable register: a multi-entry register file.
- One write port with byte enables and two independent read ports.
- Optional hardwired-zero entry 0, optional write-to-read bypass and optional registered reads.
- A sequenced bulk-clear command zeroes the file one entry per cycle.
- Sits in the processor datapath as the architectural GPR file.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of entries; any value ≥2, power of two not required.
- AW, $clog2(DEPTH), address width (derived localparam; do not override).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read port.
- READ_REG, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- wbe  in  WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
- raddr_a  in  AW  read address, port A.
- rdata_a  out  WIDTH  read data, port A.
- raddr_b  in  AW  read address, port B.
- rdata_b  out  WIDTH  read data, port B.
- clr  in  1  bulk-clear request, single-cycle pulse.
- busy  out  1  bulk clear in progress.
- wr_drop  out  1  a write was rejected this cycle.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset:
  - All entries go to 0.
  - FSM goes to IDLE; clear counter goes to 0; busy=0.
  - With READ_REG=1, rdata_a and rdata_b registers go to 0.
  - Reset mid-clear aborts the sweep immediately; all entries are 0 regardless.
- Write accept: at a rising clk edge with we=1 and busy=0, waddr < DEPTH, and not (ZERO_REG=1 and waddr=0).
  - Only bytes with wbe[i]=1 are updated; other bytes keep their value.
  - wbe=0 is a legal no-op.
- Write reject: a write with busy=1 is dropped.
  - wr_drop = we & busy (combinational), so the pulse appears in the same cycle as the rejected write.
  - Out-of-range and zero-register writes are silently ignored; wr_drop stays 0 for these.
- Read data value, per port:
  - raddr ≥ DEPTH reads 0.
  - ZERO_REG=1 with raddr=0 reads 0.
  - Otherwise the stored word.
- Bypass (BYPASS=1): if an accepted write targets the same address as a read port in the same cycle, that port returns the merged word.
  - Merged word = wdata bytes where wbe=1, stored bytes elsewhere.
  - Both ports bypass independently.
- No bypass (BYPASS=0): a combinational read returns the pre-write value in the write cycle.
- READ_REG=0: rdata is combinational from raddr, with bypass applied as above.
- READ_REG=1: rdata is updated at the clock edge with the value the READ_REG=0 path shows that cycle, so data appears one cycle after raddr.
  - The register captures the merged word when BYPASS=1 and the pre-write word when BYPASS=0.
- Bulk-clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on clr=1 with busy=0; counter loads 0.
  - busy is 1 exactly while in CLEAR; it is registered from the FSM state, so it rises the cycle after clr.
  - In CLEAR, each cycle zeroes entry[counter] and increments the counter.
  - At counter=DEPTH-1: the entry is zeroed, the FSM returns to IDLE and busy falls on the next cycle.
  - busy stays high for exactly DEPTH cycles.
  - clr while busy=1 is ignored.
  - A write in the same cycle as the accepted clr is accepted (busy=0), then cleared by the sweep.
  - Reads during CLEAR are allowed and return current, partially cleared contents; no bypass applies since no write is accepted.

Test Plan:
- Reset, then basic write/read:
  - Write 0xDEADBEEF to addr 5, wbe=0xF; next cycle raddr_a=5 → rdata_a=0xDEADBEEF.
  - raddr_b=6 → 0.
- Byte enables:
  - Write 0xFFFFFFFF to addr 3, then 0x12345678 to addr 3 with wbe=0x5 → addr 3 reads 0xFF34FF78.
- Zero register:
  - Write 0xAAAAAAAA to addr 0 → reads 0 on both ports; wr_drop=0.
- Bypass with READ_REG=0, BYPASS=1:
  - addr 7 holds 0x11111111; write 0x22222222 to addr 7 with wbe=0x3 while raddr_a=7.
  - Same cycle rdata_a=0x11112222.
  - Repeat with BYPASS=0 → 0x11111111.
- READ_REG=1:
  - raddr_b=5 changes at edge N → rdata_b=0xDEADBEEF after edge N+1.
  - Assert rst asynchronously mid-cycle → rdata_b=0 immediately.
- Bulk clear, DEPTH=32, with several entries nonzero:
  - Pulse clr → busy high for 32 cycles.
  - we=1 during busy → wr_drop=1 and the write is lost.
  - Second clr mid-sweep is ignored.
  - After busy falls, all entries read 0.
  - Assert rst at sweep cycle 10 → busy=0 immediately and all entries read 0.
